// File: rtl/excalibur_inventory_ctrl_if.sv
// ---------------------------------------------------------------------------
// excalibur_inventory_ctrl_if
//
// Purpose: groups the game-logic / overlay signals of the Excalibur
// inventory controller into one bundle.
//
// Signals:
//   frame_tick            game -> ctrl  one-cycle pulse per video frame
//   game_clear            game -> ctrl  synchronous clear of count and FSM
//   pickup                game -> ctrl  one-cycle pulse, add one charge
//   use_req               game -> ctrl  level request to spend a charge
//   use_grant             ctrl -> game  one-cycle pulse, a charge was spent
//   Excalibur_icon_number ctrl -> ovl   current charge count (2 bits)
//   Excalibur_icon_exist  ctrl -> ovl   icon overlay enable
//   cooldown_active       ctrl -> game  high while uses are blocked
//   count_full            ctrl -> game  count is at its saturation limit
//
// Modports: master = game logic side, slave = the controller.
// ---------------------------------------------------------------------------
interface excalibur_inventory_ctrl_if;
  logic       frame_tick;
  logic       game_clear;
  logic       pickup;
  logic       use_req;
  logic       use_grant;
  logic [1:0] Excalibur_icon_number;
  logic       Excalibur_icon_exist;
  logic       cooldown_active;
  logic       count_full;

  modport master (
    output frame_tick, game_clear, pickup, use_req,
    input  use_grant, Excalibur_icon_number, Excalibur_icon_exist,
           cooldown_active, count_full
  );

  modport slave (
    input  frame_tick, game_clear, pickup, use_req,
    output use_grant, Excalibur_icon_number, Excalibur_icon_exist,
           cooldown_active, count_full
  );
endinterface

// File: rtl/excalibur_inventory_ctrl.sv
// ---------------------------------------------------------------------------
// excalibur_inventory_ctrl
//
// Purpose: owns the player's Excalibur charge count, accepts pickups and use
// requests, enforces a frame-tick cooldown between uses and drives the icon
// overlay inputs. All outputs are registered.
//
// Ports:
//   Clk    single system/pixel clock
//   Reset  asynchronous, active-high reset
//   bus    excalibur_inventory_ctrl_if.slave (see interface file)
//
// Parameters:
//   MAX_COUNT        saturation limit of the count (1..3)
//   INIT_COUNT       count loaded on reset and game_clear (<= MAX_COUNT)
//   COOLDOWN_FRAMES  frame ticks spent in COOLDOWN after a grant (1..1023)
//   BLINK_FRAMES     blink half-period in frame ticks (blink build only)
//
// Build option: define EXC_BLINK_EN to blink the icon during cooldown.
// ---------------------------------------------------------------------------
module excalibur_inventory_ctrl #(
  parameter int MAX_COUNT       = 3,
  parameter int INIT_COUNT      = 0,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  excalibur_inventory_ctrl_if.slave  bus
);

  localparam int         CD_W    = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [1:0] MAX_C   = 2'(MAX_COUNT);
  localparam logic [1:0] INIT_C  = 2'(INIT_COUNT);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  // Elaboration-time guard against parameter sets the 2-bit count or the
  // cooldown counter cannot represent.
  if (MAX_COUNT < 1 || MAX_COUNT > 3 || INIT_COUNT < 0 ||
      INIT_COUNT > MAX_COUNT || COOLDOWN_FRAMES < 1 ||
      COOLDOWN_FRAMES > 1023 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("excalibur_inventory_ctrl: illegal parameter set");
  end

  typedef enum logic {READY, COOLDOWN} state_t;

  state_t          state, state_next;
  logic [1:0]      count, count_next;
  logic [CD_W-1:0] cd_cnt, cd_next;
  logic            grant_q, grant_next;
  logic            exist_q, exist_next;
  logic            full_q;
  logic            accept;

  // Next-state logic. game_clear wins over everything; otherwise a use is
  // accepted only from READY with a charge available, and a simultaneous
  // pickup cancels the decrement so the count is unchanged net. The tick
  // that lands on the grant edge is ignored because the state is still
  // READY then; the tick that takes the counter from 1 to 0 re-opens READY.
  always_comb begin
    state_next = state;
    count_next = count;
    cd_next    = cd_cnt;
    grant_next = 1'b0;
    accept     = (state == READY) && bus.use_req && (count != 2'd0) &&
                 !bus.game_clear;

    if (bus.game_clear) begin
      state_next = READY;
      count_next = INIT_C;
      cd_next    = '0;
    end else begin
      if (accept && !bus.pickup) begin
        count_next = count - 2'd1;
      end else if (!accept && bus.pickup && (count != MAX_C)) begin
        count_next = count + 2'd1;
      end

      if (accept) begin
        grant_next = 1'b1;
        state_next = COOLDOWN;
        cd_next    = CD_LOAD;
      end else if ((state == COOLDOWN) && bus.frame_tick) begin
        cd_next = cd_cnt - CD_W'(1);
        if (cd_cnt == CD_W'(1)) begin
          state_next = READY;
        end
      end
    end
  end

`ifdef EXC_BLINK_EN
  localparam int BL_W = $clog2(BLINK_FRAMES + 1);

  logic [BL_W-1:0] blink_cnt, blink_cnt_next;
  logic            blink_on, blink_on_next;

  // Blink phase generator. It is held at zero/low whenever the controller is
  // in READY or is just entering COOLDOWN, so every cooldown starts with the
  // icon dark at the grant edge and toggles every BLINK_FRAMES ticks.
  always_comb begin
    blink_cnt_next = blink_cnt;
    blink_on_next  = blink_on;
    if ((state == READY) || (state_next == READY)) begin
      blink_cnt_next = '0;
      blink_on_next  = 1'b0;
    end else if (bus.frame_tick) begin
      if (blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_next = '0;
        blink_on_next  = ~blink_on;
      end else begin
        blink_cnt_next = blink_cnt + BL_W'(1);
      end
    end
  end

  // Icon is shown whenever charges exist, except during the dark half of
  // the cooldown blink.
  always_comb begin
    exist_next = (count_next != 2'd0) &&
                 ((state_next == READY) || blink_on_next);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;
    end
  end
`else
  // Without blinking the icon simply mirrors whether any charge is held.
  always_comb begin
    exist_next = (count_next != 2'd0);
  end
`endif

  // State and output registers; reset mirrors the game_clear values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= READY;
      count   <= INIT_C;
      cd_cnt  <= '0;
      grant_q <= 1'b0;
      exist_q <= (INIT_C != 2'd0);
      full_q  <= (INIT_C == MAX_C);
    end else begin
      state   <= state_next;
      count   <= count_next;
      cd_cnt  <= cd_next;
      grant_q <= grant_next;
      exist_q <= exist_next;
      full_q  <= (count_next == MAX_C);
    end
  end

  assign bus.use_grant             = grant_q;
  assign bus.Excalibur_icon_number = count;
  assign bus.Excalibur_icon_exist  = exist_q;
  assign bus.cooldown_active       = (state == COOLDOWN);
  assign bus.count_full            = full_q;

endmodule

// File: tb/tb_excalibur_inventory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_excalibur_inventory_ctrl
//
// Directed scoreboard bench for excalibur_inventory_ctrl with MAX_COUNT=3,
// INIT_COUNT=0, COOLDOWN_FRAMES=30, BLINK_FRAMES=8. Stimulus pushes the
// expected status snapshot (and expected grant cycles) into queues; a
// monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_excalibur_inventory_ctrl;

`ifdef EXC_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  excalibur_inventory_ctrl_if bus ();

  excalibur_inventory_ctrl #(
    .MAX_COUNT       (3),
    .INIT_COUNT      (0),
    .COOLDOWN_FRAMES (30),
    .BLINK_FRAMES    (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Edge counter: value after the Nth rising edge is N.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] num;
    logic       exist;
    logic       cd;
    logic       full;
  } snap_t;

  snap_t status_q[$];
  int    grant_q[$];
  int    checks = 0;
  int    errors = 0;

  // Drive one cycle of inputs, settled well before the next rising edge.
  task automatic applyStimulus(input logic tick, input logic clr,
                               input logic pk, input logic req);
    @(negedge Clk);
    bus.frame_tick = tick;
    bus.game_clear = clr;
    bus.pickup     = pk;
    bus.use_req    = req;
  endtask

  // Expected status right after the upcoming rising edge.
  task automatic checkOutput(input string name, input logic [1:0] num,
                             input logic exist, input logic cd,
                             input logic full);
    snap_t s;
    s.cyc   = cyc + 1;
    s.name  = name;
    s.num   = num;
    s.exist = exist;
    s.cd    = cd;
    s.full  = full;
    status_q.push_back(s);
  endtask

  task automatic expectGrant();
    grant_q.push_back(cyc + 1);
  endtask

  // Expected icon enable k ticks into a cooldown with a nonzero count.
  function automatic logic blinkExist(input int k);
    if (!BLINK) return 1'b1;
    return ((k / 8) % 2) == 1;
  endfunction

  // Monitor: compares grants and queued snapshots away from the active edge.
  always @(negedge Clk) begin
    if (bus.use_grant === 1'b1) begin
      checks++;
      if (grant_q.size() != 0 && grant_q[0] == cyc) begin
        void'(grant_q.pop_front());
      end else begin
        errors++;
        $display("[TB] FAIL unexpected_grant at cycle %0d: use_grant=1 required=0", cyc);
      end
    end
    while (grant_q.size() != 0 && grant_q[0] < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_grant: use_grant=0 at cycle %0d required=1", grant_q[0]);
      void'(grant_q.pop_front());
    end
    while (status_q.size() != 0 && status_q[0].cyc <= cyc) begin
      snap_t s;
      s = status_q.pop_front();
      checks++;
      if (s.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: snapshot for cycle %0d never compared", s.name, s.cyc);
      end else if (bus.Excalibur_icon_number !== s.num ||
                   bus.Excalibur_icon_exist  !== s.exist ||
                   bus.cooldown_active       !== s.cd ||
                   bus.count_full            !== s.full) begin
        errors++;
        $display("[TB] FAIL %s @%0d: num/exist/cd/full actual=%0d/%0b/%0b/%0b required=%0d/%0b/%0b/%0b",
                 s.name, cyc, bus.Excalibur_icon_number, bus.Excalibur_icon_exist,
                 bus.cooldown_active, bus.count_full, s.num, s.exist, s.cd, s.full);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] pk_num  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       pk_full [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    bus.frame_tick = 1'b0;
    bus.game_clear = 1'b0;
    bus.pickup     = 1'b0;
    bus.use_req    = 1'b0;

    // Reset state
    repeat (3) @(negedge Clk);
    checkOutput("reset_state", 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    // Four pickups saturate at 3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("pickup_%0d", i), pk_num[i], 1'b1, 1'b0, pk_full[i]);
    end

    // Clear, then build count 2
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pickup_a", 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pickup_b", 2'd2, 1'b1, 1'b0, 1'b0);

    // Held use_req: grant, 30-tick cooldown, re-grant one cycle later
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expectGrant();
    checkOutput("grant1", 2'd1, blinkExist(0), 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      if (k < 30) begin
        checkOutput($sformatf("cd1_tick%0d", k), 2'd1, blinkExist(k), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        checkOutput("cd1_end", 2'd1, 1'b1, 1'b0, 1'b0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expectGrant();
    checkOutput("grant2", 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("cd2_tick%0d", k), 2'd0, 1'b0, (k < 30), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("no_third_grant", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Pickup and use in the same cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pickup_to_1", 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    expectGrant();
    checkOutput("pickup_and_use", 2'd1, blinkExist(0), 1'b1, 1'b0);

    // Pickups during cooldown, then game_clear with 10 ticks remaining
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("cd_pickup_2", 2'd2, blinkExist(0), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("cd_pickup_3", 2'd3, blinkExist(0), 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("cd3_tick20", 2'd3, blinkExist(20), 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("clear_mid_cd", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("after_clear", 2'd0, 1'b0, 1'b0, 1'b0);

    // Empty inventory: 100 cycles of requests, never a grant
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("empty_req", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a cooldown
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_pickup", 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expectGrant();
    checkOutput("pre_rst_grant", 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge Clk);
    #2;
    Reset          = 1'b1;
    bus.frame_tick = 1'b0;
    checkOutput("reset_mid_cd", 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_reset_pickup", 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Drain and make sure every expectation was consumed
    repeat (3) @(negedge Clk);
    checks++;
    if (status_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL status_drain: pending=%0d required=0", status_q.size());
    end
    checks++;
    if (grant_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL grant_drain: pending=%0d required=0", grant_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/excalibur_inventory_ctrl.md
# excalibur_inventory_ctrl

Controller that owns the player's Excalibur charge count and drives the icon sprite overlay's `Excalibur_icon_exist` / `Excalibur_icon_number` inputs. It accepts pickup events and use requests from game logic, enforces a frame-based cooldown between uses, and issues a one-cycle use grant to the attack logic. It sits between the game-state logic and the icon overlay, and is clocked on the pixel/system clock with a per-frame tick.

## Interface

- `MAX_COUNT`, default 3: saturation limit for the charge count; legal range 1..3 because the icon number field is 2 bits.
- `INIT_COUNT`, default 0: count loaded on reset and on `game_clear`; must not exceed `MAX_COUNT`.
- `COOLDOWN_FRAMES`, default 30: number of frame ticks spent in COOLDOWN after a grant; legal range 1..1023.
- `BLINK_FRAMES`, default 8: half-period of the cooldown blink, in frame ticks. Used only with `EXC_BLINK_EN`.

- `Clk`, input, 1 bit: single clock.
- `Reset`, input, 1 bit: asynchronous, active-high reset.
- `frame_tick`, input, 1 bit: one-cycle pulse, once per video frame.
- `game_clear`, input, 1 bit: synchronous clear; count returns to `INIT_COUNT` and the FSM returns to READY.
- `pickup`, input, 1 bit: one-cycle pulse, add one charge.
- `use_req`, input, 1 bit: level request to spend one charge.
- `use_grant`, output, 1 bit: one-cycle pulse, a charge was spent.
- `Excalibur_icon_number`, output, 2 bits: current count.
- `Excalibur_icon_exist`, output, 1 bit: icon overlay enable.
- `cooldown_active`, output, 1 bit: high while in COOLDOWN.
- `count_full`, output, 1 bit: high when count equals `MAX_COUNT`.

## Operation

- FSM states:
  - READY: uses are allowed.
  - COOLDOWN: uses are blocked.
- Count register, 2 bits:
  - A pickup increments the count, saturating at `MAX_COUNT`. A pickup at full is dropped silently.
  - A grant decrements the count.
- Use acceptance:
  - A use is accepted only when the state is READY, `use_req` = 1 and count > 0.
  - On acceptance: `use_grant` = 1 for one cycle, count decrements, state moves to COOLDOWN, and the cooldown counter loads `COOLDOWN_FRAMES`.
  - A request with count = 0, or during COOLDOWN, is ignored. No grant is issued and nothing is queued.
  - `use_req` held high re-arms automatically: the next grant comes on the first eligible cycle after COOLDOWN ends.
- Cooldown counter:
  - Width is ceil(log2(`COOLDOWN_FRAMES`+1)).
  - Decrements on each `frame_tick` seen while in COOLDOWN.
  - The tick that brings it to 0 returns the state to READY.
- Pickup and accepted use in the same cycle: count is unchanged net, the grant is still issued, and cooldown still starts.
- Pickups are accepted in both states.
- `game_clear` has priority over every other input in its cycle. `use_grant` is 0 that cycle, the count loads `INIT_COUNT`, the state goes to READY and the counters are zeroed.
- `Excalibur_icon_exist` = (count != 0), gated by blink (see Configuration).
- `count_full` = (count == `MAX_COUNT`).

## Timing

- All outputs are registered.
- Reset values:
  - `use_grant` = 0
  - `Excalibur_icon_number` = `INIT_COUNT`
  - `Excalibur_icon_exist` = (`INIT_COUNT` != 0)
  - `cooldown_active` = 0
  - `count_full` = (`INIT_COUNT` == `MAX_COUNT`)
  - state = READY
  - cooldown and blink counters = 0
- Grant latency: `use_req` sampled high at edge N produces `use_grant` high from edge N to edge N+1. The count, state and `cooldown_active` update at the same edge N.
- Pickup sampled at edge N updates `Excalibur_icon_number` at edge N.
- Cooldown length:
  - A `frame_tick` coincident with the grant edge is not counted.
  - READY is entered at the edge that samples the `COOLDOWN_FRAMES`-th subsequent tick.
  - The earliest next grant is at the following edge.
- Reset asserted mid-cooldown aborts the cooldown immediately and returns all outputs to their reset values.

## Configuration

- `EXC_BLINK_EN` defined:
  - While in COOLDOWN with count != 0, `Excalibur_icon_exist` toggles every `BLINK_FRAMES` frame ticks, starting low at the grant edge.
  - A blink counter counts frame ticks and wraps at `BLINK_FRAMES`.
  - On return to READY, `Excalibur_icon_exist` = (count != 0) at that same edge.
- `EXC_BLINK_EN` undefined: no blink counter is built, and `Excalibur_icon_exist` = (count != 0) at all times.

## Test plan

- Reset with `INIT_COUNT`=0, then 4 pickups -> `Excalibur_icon_number` reads 1, 2, 3, 3; `count_full` = 1 after the third pickup.
- Count 2, `use_req` held high, `COOLDOWN_FRAMES`=30 -> first grant; a second grant exactly one cycle after the edge sampling the 30th tick; count 0; no third grant.
- Count 1, pickup and `use_req` in the same cycle in READY -> `use_grant` = 1, count stays 1, `cooldown_active` = 1.
- Count 3 in COOLDOWN with 10 ticks remaining, `game_clear` pulsed -> count = `INIT_COUNT`, READY, no grant.
- `EXC_BLINK_EN` defined, `BLINK_FRAMES`=8, count 2 at grant -> `Excalibur_icon_exist` goes low at the grant edge, high after 8 ticks, low after 16, and high on return to READY.
- Count 0, `use_req` held high for 100 cycles -> `use_grant` never asserts and the state stays READY.
